// File: rtl/dmem_pkg.sv
// Shared types and helpers for the memory-stage bridge.
// Holds the FSM state encoding and the address legality check.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int OFFSET_BITS = 3;
   localparam int ADDR_MAX_W  = 64;

   // An address is illegal if it is not doubleword aligned or falls past 2^aw doublewords.
   function automatic logic addr_fault(input logic [ADDR_MAX_W-1:0] addr,
                                       input int unsigned aw);
      logic misaligned;
      logic out_of_range;
      misaligned   = addr[OFFSET_BITS-1:0] != '0;
      out_of_range = (addr >> (aw + OFFSET_BITS)) != '0;
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/dmem_timer.sv
// Saturating count of BUSY cycles; o_expired flags the abort cycle.
// Clear has priority over enable.
module dmem_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != TC)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = i_en && (r_count == TC);

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: one req/ack transaction per load/store, pipeline stalled
// until completion, illegal addresses rejected without a memory request.
//
// state | meaning
// IDLE  | evaluate the access at EX/MEM; legal access starts a request
// BUSY  | request outstanding, waiting for mem_ack or timeout
// DONE  | one unstalled cycle so MEM/WB captures DM_readData
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int N       = 64,
   parameter int AW      = 9,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  DM_addr,
   input  logic [N-1:0]  DM_writeData,
   input  logic          DM_readEnable,
   input  logic          DM_writeEnable,
   output logic [N-1:0]  DM_readData,
   output logic          stall_M,
   output logic          fault_M,
   output logic          timeout_err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [N-1:0]  mem_wdata,
   input  logic          mem_ack,
   input  logic [N-1:0]  mem_rdata
);

   dmem_state_t r_state;

   logic w_access;
   logic w_fault;
   logic w_is_read;
   logic w_start;
   logic w_busy;
   logic w_expired;
   logic w_timer_clr;

   assign w_access  = DM_readEnable | DM_writeEnable;
   assign w_fault   = w_access & addr_fault(64'(DM_addr), AW);
   // With both enables high the access is a store.
   assign w_is_read = DM_readEnable & ~DM_writeEnable;
   assign w_start   = (r_state == IDLE) & w_access & ~w_fault;
   assign w_busy    = (r_state == BUSY);

   assign stall_M = w_start | w_busy;
   assign fault_M = w_fault;

   assign w_timer_clr = ~w_busy | mem_ack | w_expired;

   dmem_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_timer_clr),
      .i_en      (w_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         DM_readData <= '0;
         timeout_err <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  mem_we    <= DM_writeEnable;
                  mem_addr  <= DM_addr[AW+OFFSET_BITS-1:OFFSET_BITS];
                  mem_wdata <= DM_writeData;
                  mem_req   <= 1'b1;
                  r_state   <= BUSY;
               end else if (w_fault && w_is_read) begin
                  DM_readData <= '0;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  if (!mem_we) DM_readData <= mem_rdata;
                  mem_req <= 1'b0;
                  r_state <= DONE;
               end else if (w_expired) begin
                  timeout_err <= 1'b1;
                  if (!mem_we) DM_readData <= '0;
                  mem_req <= 1'b0;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
